// File: rtl/stw_bist_sequencer_if.sv
// Stop-the-world self-test port between the BIST sequencer and the systolic array.
// The sequencer drives vectors and triggers; the array returns completion and per-PE results.
interface stw_bist_sequencer_if #(
  parameter int ROWS      = 3,
  parameter int COLS      = 3,
  parameter int WORD_SIZE = 16
);
  logic                   STW_test_load_en;
  logic [WORD_SIZE-1:0]   STW_mult_op1;
  logic [WORD_SIZE-1:0]   STW_mult_op2;
  logic [WORD_SIZE-1:0]   STW_add_op;
  logic [WORD_SIZE-1:0]   STW_expected;
  logic                   STW_start;
  logic                   STW_complete;
  logic [ROWS*COLS-1:0]   STW_result_mat;

  modport master (
    output STW_test_load_en, STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected, STW_start,
    input  STW_complete, STW_result_mat
  );

  modport slave (
    input  STW_test_load_en, STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected, STW_start,
    output STW_complete, STW_result_mat
  );
endinterface

// File: rtl/stw_bist_sequencer.sv
// BIST sequencer for the systolic array STW port: freezes matmul traffic, applies a fixed
// vector table, ANDs per-PE results into a health map and reports the fault count.
//
// state | meaning
// IDLE  | results held; waits for bist_start
// LOAD  | vector presented with STW_test_load_en
// START | one-cycle STW_start trigger, operands held
// WAIT  | waits for STW_complete (ignored in first WAIT cycle) or timeout
// DONE  | one-cycle bist_done; fault_count/any_fault valid from here
module stw_bist_sequencer #(
  parameter int ROWS        = 3,
  parameter int COLS        = 3,
  parameter int WORD_SIZE   = 16,
  parameter int NUM_VECTORS = 4,
  parameter int TIMEOUT     = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              bist_start,
  output logic                              bist_busy,
  output logic                              hold_array,
  output logic                              bist_done,
  stw_bist_sequencer_if.master              stw,
  output logic [ROWS*COLS-1:0]              fault_map,
  output logic [$clog2(ROWS*COLS+1)-1:0]    fault_count,
  output logic                              any_fault,
  output logic                              timeout_err
);

  localparam int N  = ROWS * COLS;
  localparam int CW = $clog2(N + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] WAIT_FIRST = TW'(TIMEOUT - 1);
  localparam logic [1:0]    LAST_VEC   = 2'(NUM_VECTORS - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_DONE} state_t;

  typedef struct packed {
    logic [WORD_SIZE-1:0] op1;
    logic [WORD_SIZE-1:0] op2;
    logic [WORD_SIZE-1:0] add;
    logic [WORD_SIZE-1:0] exp;
  } vec_t;

  state_t          state, state_n;
  logic [1:0]      vec_idx, vec_idx_n;
  logic [TW-1:0]   wait_cnt, wait_cnt_n;
  logic [N-1:0]    map_n;
  logic [CW-1:0]   count_n;
  logic            any_n;
  logic            tout_n;
  logic            accept;

  function automatic vec_t vec_lookup(input logic [1:0] idx);
    logic [WORD_SIZE-1:0] pat_a;
    vec_t v;
    for (int i = 0; i < WORD_SIZE; i++) pat_a[i] = (i % 2 == 0);
    v = '0;
    case (idx)
      2'd0: begin
        v.op1 = WORD_SIZE'(4);
        v.op2 = WORD_SIZE'(3);
        v.add = '0;
        v.exp = WORD_SIZE'(12);
      end
      2'd1: begin
        v.op1 = WORD_SIZE'(1);
        v.op2 = '1;
        v.add = WORD_SIZE'(1);
        v.exp = '0;
      end
      2'd2: begin
        v.op1 = pat_a;
        v.op2 = WORD_SIZE'(1);
        v.add = '0;
        v.exp = pat_a;
      end
      default: begin
        v.op1 = ~pat_a;
        v.op2 = WORD_SIZE'(1);
        v.add = pat_a;
        v.exp = '1;
      end
    endcase
    return v;
  endfunction

  function automatic logic [CW-1:0] count_zeros(input logic [N-1:0] m);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) if (!m[i]) c = c + CW'(1);
    return c;
  endfunction

  // The first WAIT cycle (counter still at its load value) never accepts, masking a
  // complete level left over from the previous vector.
  assign accept = stw.STW_complete && (wait_cnt != WAIT_FIRST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      vec_idx  <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_n;
      vec_idx  <= vec_idx_n;
      wait_cnt <= wait_cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    vec_idx_n  = vec_idx;
    wait_cnt_n = wait_cnt;
    map_n      = fault_map;
    tout_n     = timeout_err;
    count_n    = fault_count;
    any_n      = any_fault;
    case (state)
      S_IDLE: begin
        if (bist_start) begin
          state_n   = S_LOAD;
          vec_idx_n = '0;
          map_n     = '1;
          tout_n    = 1'b0;
          count_n   = '0;
          any_n     = 1'b0;
        end
      end
      S_LOAD:  state_n = S_START;
      S_START: begin
        state_n    = S_WAIT;
        wait_cnt_n = WAIT_FIRST;
      end
      S_WAIT: begin
        if (accept) begin
          map_n = fault_map & stw.STW_result_mat;
          if (vec_idx == LAST_VEC) begin
            state_n = S_DONE;
          end else begin
            vec_idx_n = vec_idx + 2'd1;
            state_n   = S_LOAD;
          end
        end else if (wait_cnt == '0) begin
          state_n = S_DONE;
          tout_n  = 1'b1;
          map_n   = '0;
        end else begin
          wait_cnt_n = wait_cnt - TW'(1);
        end
        if (state_n == S_DONE) begin
          count_n = count_zeros(map_n);
          any_n   = (count_n != '0) || tout_n;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bist_busy            <= 1'b0;
      hold_array           <= 1'b0;
      bist_done            <= 1'b0;
      stw.STW_test_load_en <= 1'b0;
      stw.STW_start        <= 1'b0;
      stw.STW_mult_op1     <= '0;
      stw.STW_mult_op2     <= '0;
      stw.STW_add_op       <= '0;
      stw.STW_expected     <= '0;
      fault_map            <= '1;
      fault_count          <= '0;
      any_fault            <= 1'b0;
      timeout_err          <= 1'b0;
    end else begin
      bist_busy            <= (state_n == S_LOAD) || (state_n == S_START) || (state_n == S_WAIT);
      hold_array           <= (state_n == S_LOAD) || (state_n == S_START) || (state_n == S_WAIT);
      bist_done            <= (state_n == S_DONE);
      stw.STW_test_load_en <= (state_n == S_LOAD);
      stw.STW_start        <= (state_n == S_START);
      if (state_n == S_LOAD) begin
        stw.STW_mult_op1 <= vec_lookup(vec_idx_n).op1;
        stw.STW_mult_op2 <= vec_lookup(vec_idx_n).op2;
        stw.STW_add_op   <= vec_lookup(vec_idx_n).add;
        stw.STW_expected <= vec_lookup(vec_idx_n).exp;
      end
      fault_map   <= map_n;
      fault_count <= count_n;
      any_fault   <= any_n;
      timeout_err <= tout_n;
    end
  end

endmodule
